// File: rtl/jtag_port_gen.sv
// JTAG-style debug port on the system clock: generic IR/DR shift chains, an update handshake
// towards the MCU with an overrun flag, and separate MCU write/read buses for the data register.
module jtag_port_gen #(
    parameter int                     IR_WIDTH  = 8,
    parameter int                     DR_WIDTH  = 16,
    parameter logic [IR_WIDTH-1:0]    NOP_INSTR = {IR_WIDTH{1'b0}},
    parameter bit                     LSB_FIRST = 1'b0,
    localparam int                    CNT_W     = $clog2(DR_WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tckSynch,
    input  logic                tmsSynch,
    input  logic                tdiSynch,
    output logic                tdo,
    input  logic                wrData,
    input  logic [DR_WIDTH-1:0] wrDataVal,
    output logic [DR_WIDTH-1:0] rdData,
    output logic [IR_WIDTH-1:0] instrLine,
    output logic                updReq,
    input  logic                updAck,
    output logic                updOvr,
    output logic                inDShift,
    output logic [CNT_W-1:0]    drCount
);

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_SEL_I   = 3'b100;
    localparam logic [2:0] ST_SEL_D   = 3'b110;
    localparam logic [2:0] ST_SHIFT_I = 3'b101;
    localparam logic [2:0] ST_SHIFT_D = 3'b111;
    localparam logic [2:0] ST_UPDATE  = 3'b001;

    function automatic logic [IR_WIDTH-1:0] ir_shift(input logic [IR_WIDTH-1:0] v, input logic b);
        if (LSB_FIRST) begin
            ir_shift = {b, v[IR_WIDTH-1:1]};
        end else begin
            ir_shift = {v[IR_WIDTH-2:0], b};
        end
    endfunction

    function automatic logic [DR_WIDTH-1:0] dr_shift(input logic [DR_WIDTH-1:0] v, input logic b);
        if (LSB_FIRST) begin
            dr_shift = {b, v[DR_WIDTH-1:1]};
        end else begin
            dr_shift = {v[DR_WIDTH-2:0], b};
        end
    endfunction

    logic                tck_prev_q;
    logic [2:0]          state_q,   state_d;
    logic [IR_WIDTH-1:0] ir_q,      ir_d;
    logic [DR_WIDTH-1:0] dr_q,      dr_d;
    logic [IR_WIDTH-1:0] instr_q,   instr_d;
    logic                upd_req_q, upd_req_d;
    logic                upd_ovr_q, upd_ovr_d;
    logic [CNT_W-1:0]    dr_cnt_q,  dr_cnt_d;
    logic                tck_edge_s;
    logic                upd_entry_s;
    logic                ir_out_s;
    logic                dr_out_s;

    assign tck_edge_s = tckSynch & ~tck_prev_q;

    // TAP-style state walk, advanced only on detected TCK rising edges
    always_comb begin
        state_d = state_q;
        if (tck_edge_s) begin
            case (state_q)
                ST_IDLE,
                ST_UPDATE:  state_d = tmsSynch ? ST_IDLE   : ST_SEL_I;
                ST_SEL_I:   state_d = tmsSynch ? ST_SEL_D  : ST_SHIFT_I;
                ST_SEL_D:   state_d = tmsSynch ? ST_IDLE   : ST_SHIFT_D;
                ST_SHIFT_I: state_d = tmsSynch ? ST_UPDATE : ST_SHIFT_I;
                ST_SHIFT_D: state_d = tmsSynch ? ST_UPDATE : ST_SHIFT_D;
                default:    state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Shift chains and DR bit counter; MCU writes are locked out only while shifting DR
    always_comb begin
        ir_d     = ir_q;
        dr_d     = dr_q;
        dr_cnt_d = dr_cnt_q;
        if (wrData && (state_q != ST_SHIFT_D)) begin
            dr_d = wrDataVal;
        end else begin
            dr_d = dr_q;
        end
        if (tck_edge_s) begin
            case (state_q)
                ST_SHIFT_I: ir_d = ir_shift(ir_q, tdiSynch);
                ST_SHIFT_D: begin
                    dr_d = dr_shift(dr_q, tdiSynch);
                    if (dr_cnt_q == CNT_W'(DR_WIDTH)) begin
                        dr_cnt_d = dr_cnt_q;
                    end else begin
                        dr_cnt_d = dr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SEL_D: begin
                    if (!tmsSynch) begin
                        dr_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        dr_cnt_d = dr_cnt_q;
                    end
                end
                ST_UPDATE:  ir_d = NOP_INSTR;
                default:    ir_d = ir_q;
            endcase
        end else begin
            ir_d = ir_q;
        end
    end

    assign upd_entry_s = tck_edge_s && (state_d == ST_UPDATE) && (state_q != ST_UPDATE);

    // Update handshake: an ack in the entry cycle frees the slot for the new instruction
    always_comb begin
        instr_d   = instr_q;
        upd_req_d = upd_req_q;
        upd_ovr_d = upd_ovr_q;
        if (upd_entry_s) begin
            if (!upd_req_q || updAck) begin
                instr_d   = ir_d;
                upd_req_d = 1'b1;
                upd_ovr_d = upd_ovr_q;
            end else begin
                instr_d   = instr_q;
                upd_req_d = 1'b1;
                upd_ovr_d = 1'b1;
            end
        end else if (updAck) begin
            upd_req_d = 1'b0;
            upd_ovr_d = 1'b0;
        end else begin
            upd_req_d = upd_req_q;
            upd_ovr_d = upd_ovr_q;
        end
    end

    // State registers; tck_prev starts high so a TCK already high at reset is not an edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tck_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            ir_q       <= NOP_INSTR;
            dr_q       <= {DR_WIDTH{1'b0}};
            instr_q    <= NOP_INSTR;
            upd_req_q  <= 1'b0;
            upd_ovr_q  <= 1'b0;
            dr_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            tck_prev_q <= tckSynch;
            state_q    <= state_d;
            ir_q       <= ir_d;
            dr_q       <= dr_d;
            instr_q    <= instr_d;
            upd_req_q  <= upd_req_d;
            upd_ovr_q  <= upd_ovr_d;
            dr_cnt_q   <= dr_cnt_d;
        end
    end

    assign ir_out_s  = LSB_FIRST ? ir_q[0] : ir_q[IR_WIDTH-1];
    assign dr_out_s  = LSB_FIRST ? dr_q[0] : dr_q[DR_WIDTH-1];
    assign tdo       = ((state_q == ST_SEL_D) || (state_q == ST_SHIFT_D)) ? dr_out_s : ir_out_s;
    assign rdData    = dr_q;
    assign instrLine = instr_q;
    assign updReq    = upd_req_q;
    assign updOvr    = upd_ovr_q;
    assign inDShift  = (state_q == ST_SHIFT_D);
    assign drCount   = dr_cnt_q;

    jtag_port_gen_chk #(
        .DR_WIDTH (DR_WIDTH),
        .CNT_W    (CNT_W)
    ) u_chk (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .state_i   (state_q),
        .upd_req_i (upd_req_q),
        .upd_ovr_i (upd_ovr_q),
        .dr_cnt_i  (dr_cnt_q)
    );

endmodule

// Invariant checker for jtag_port_gen: legal state codes, overrun only with a pending
// request, and a DR counter that never passes the register width.
module jtag_port_gen_chk #(
    parameter int DR_WIDTH = 16,
    parameter int CNT_W    = 5
) (
    input logic             clk_i,
    input logic             rstn_i,
    input logic [2:0]       state_i,
    input logic             upd_req_i,
    input logic             upd_ovr_i,
    input logic [CNT_W-1:0] dr_cnt_i
);

    a_state_legal: assert property (@(posedge clk_i) disable iff (!rstn_i)
        state_i inside {3'b000, 3'b100, 3'b110, 3'b101, 3'b111, 3'b001});

    a_ovr_needs_req: assert property (@(posedge clk_i) disable iff (!rstn_i)
        upd_ovr_i |-> upd_req_i);

    a_cnt_bounded: assert property (@(posedge clk_i) disable iff (!rstn_i)
        dr_cnt_i <= CNT_W'(DR_WIDTH));

endmodule

// File: tb/tb_jtag_port_gen.sv
// Bench for jtag_port_gen: MSB-first and LSB-first instances driven in parallel, checked every
// clk against an arithmetic reference model, plus directed checks on the key scenarios.
module tb_jtag_port_gen;

    localparam int IRW = 8;
    localparam int DRW = 16;

    localparam int S_IDLE = 0, S_SELI = 1, S_SELD = 2, S_SHIR = 3, S_SHDR = 4, S_UPD = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, tck, tms, tdi, wr, ack;
    logic [15:0] wv;
    logic [1:0]       tdo_w, req_w, ovr_w, shd_w;
    logic [1:0][15:0] rd_w;
    logic [1:0][7:0]  ins_w;
    logic [1:0][4:0]  cnt_w;

    jtag_port_gen #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .NOP_INSTR(8'h00), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rstn(rstn), .tckSynch(tck), .tmsSynch(tms), .tdiSynch(tdi), .tdo(tdo_w[0]),
        .wrData(wr), .wrDataVal(wv), .rdData(rd_w[0]), .instrLine(ins_w[0]), .updReq(req_w[0]),
        .updAck(ack), .updOvr(ovr_w[0]), .inDShift(shd_w[0]), .drCount(cnt_w[0]));

    jtag_port_gen #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .NOP_INSTR(8'h00), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rstn(rstn), .tckSynch(tck), .tmsSynch(tms), .tdiSynch(tdi), .tdo(tdo_w[1]),
        .wrData(wr), .wrDataVal(wv), .rdData(rd_w[1]), .instrLine(ins_w[1]), .updReq(req_w[1]),
        .updAck(ack), .updOvr(ovr_w[1]), .inDShift(shd_w[1]), .drCount(cnt_w[1]));

    int tests = 0;
    int fails = 0;
    string phase = "init";

    // Reference model, index 0 = MSB-first instance, 1 = LSB-first instance
    int          mst[2];
    int unsigned mir[2], mdr[2], minstr[2], mcnt[2];
    bit          mreq[2], movr[2];
    bit          mprev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic int unsigned shl(input int unsigned v, input int w, input int lsb, input logic b);
        if (lsb != 0) return (v / 2) + (b ? (32'd1 << (w - 1)) : 32'd0);
        return ((v * 2) + (b ? 32'd1 : 32'd0)) % (32'd1 << w);
    endfunction

    function automatic int unsigned outbit(input int unsigned v, input int w, input int lsb);
        if (lsb != 0) return v % 2;
        return (v >> (w - 1)) % 2;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mst[m] = S_IDLE; mir[m] = 0; mdr[m] = 0; minstr[m] = 0;
            mcnt[m] = 0; mreq[m] = 1'b0; movr[m] = 1'b0;
        end
        mprev = 1'b1;
    endtask

    task automatic model_step();
        bit edge_v;
        edge_v = tck && !mprev;
        mprev  = tck;
        for (int m = 0; m < 2; m++) begin
            int s, ns;
            int unsigned nir, ndr;
            s = mst[m]; ns = s; nir = mir[m]; ndr = mdr[m];
            if (wr && s != S_SHDR) ndr = wv;
            if (edge_v) begin
                case (s)
                    S_IDLE, S_UPD: ns = tms ? S_IDLE : S_SELI;
                    S_SELI:        ns = tms ? S_SELD : S_SHIR;
                    S_SELD:        ns = tms ? S_IDLE : S_SHDR;
                    S_SHIR:        ns = tms ? S_UPD  : S_SHIR;
                    default:       ns = tms ? S_UPD  : S_SHDR;
                endcase
                if (s == S_SHIR) nir = shl(mir[m], IRW, m, tdi);
                if (s == S_UPD)  nir = 0;
                if (s == S_SHDR) begin
                    ndr = shl(mdr[m], DRW, m, tdi);
                    if (mcnt[m] < DRW) mcnt[m]++;
                end
                if (s == S_SELD && !tms) mcnt[m] = 0;
            end
            if (edge_v && ns == S_UPD) begin
                if (!mreq[m] || ack) begin
                    minstr[m] = nir;
                    mreq[m]   = 1'b1;
                end else begin
                    movr[m] = 1'b1;
                end
            end else if (ack) begin
                mreq[m] = 1'b0;
                movr[m] = 1'b0;
            end
            mst[m] = ns; mir[m] = nir; mdr[m] = ndr;
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int unsigned etdo;
            etdo = (mst[m] == S_SELD || mst[m] == S_SHDR) ? outbit(mdr[m], DRW, m) : outbit(mir[m], IRW, m);
            chk($sformatf("tdo%0d", m),      32'(tdo_w[m]), etdo);
            chk($sformatf("rdData%0d", m),   32'(rd_w[m]),  mdr[m]);
            chk($sformatf("instr%0d", m),    32'(ins_w[m]), minstr[m]);
            chk($sformatf("updReq%0d", m),   32'(req_w[m]), 32'(mreq[m]));
            chk($sformatf("updOvr%0d", m),   32'(ovr_w[m]), 32'(movr[m]));
            chk($sformatf("inDShift%0d", m), 32'(shd_w[m]), 32'(mst[m] == S_SHDR));
            chk($sformatf("drCount%0d", m),  32'(cnt_w[m]), mcnt[m]);
        end
    endtask

    // One system-clock cycle with the given pin values, checked #1 after the edge
    task automatic cyc(input logic t, input logic s, input logic d, input logic w,
                       input logic [15:0] v, input logic a);
        tck = t; tms = s; tdi = d; wr = w; wv = v; ack = a;
        model_step();
        @(posedge clk); #1;
        check_all();
    endtask

    // One TCK period: a low clk cycle then a high clk cycle (the edge)
    task automatic tcyc(input logic s, input logic d, input logic a);
        cyc(1'b0, s, d, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, s, d, 1'b0, 16'h0000, a);
    endtask

    // From IDLE/UPDATE: select IR, shift val MSB first, exit to UPDATE on the last bit
    task automatic ir_load(input logic [7:0] val, input logic ack_last);
        tcyc(1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) tcyc(i == 0, val[i], (i == 0) ? ack_last : 1'b0);
    endtask

    task automatic goto_shift_d();
        tcyc(1'b0, 1'b0, 1'b0);
        tcyc(1'b1, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset with TCK high, TMS high
        phase = "reset";
        rstn = 1'b0; tck = 1'b1; tms = 1'b1; tdi = 1'b0; wr = 1'b0; wv = 16'h0000; ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        rstn = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("no_edge_idle", 32'(shd_w[0]), 32'd0);

        // 2: IR update with A5, then ack
        phase = "ir_a5";
        ir_load(8'hA5, 1'b0);
        chk("instr_a5_msb", 32'(ins_w[0]), 32'h0000_00A5);
        chk("instr_a5_lsb", 32'(ins_w[1]), 32'h0000_00A5);
        chk("req_set", 32'(req_w[0]), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("req_clr", 32'(req_w[0]), 32'd0);
        tcyc(1'b1, 1'b0, 1'b0);
        chk("ir_nop_tdo", 32'(tdo_w[0]), 32'd0);

        // 3: MSB-first DR readout of 8001, counter saturation
        phase = "dr_msb";
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h8001, 1'b0);
        goto_shift_d();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tdo_seq%0d", i), 32'(tdo_w[0]), 32'((i == 0) || (i == 15)));
            tcyc(1'b0, 1'b0, 1'b0);
        end
        chk("cnt16", 32'(cnt_w[0]), 32'd16);
        chk("rd_zero", 32'(rd_w[0]), 32'd0);
        tcyc(1'b1, 1'b0, 1'b0);
        chk("cnt_sat", 32'(cnt_w[0]), 32'd16);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        tcyc(1'b1, 1'b0, 1'b0);

        // 4: LSB-first DR readout of 0003, TDI enters at bit15
        phase = "dr_lsb";
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0);
        goto_shift_d();
        chk("lsb_tdo0", 32'(tdo_w[1]), 32'd1);
        tcyc(1'b0, 1'b1, 1'b0);
        chk("lsb_tdi_msb", 32'(rd_w[1]), 32'h0000_8001);
        chk("msb_tdi_lsb", 32'(rd_w[0]), 32'h0000_0007);
        chk("lsb_tdo1", 32'(tdo_w[1]), 32'd1);
        tcyc(1'b0, 1'b0, 1'b0);
        chk("lsb_tdo2", 32'(tdo_w[1]), 32'd0);
        for (int i = 0; i < 13; i++) tcyc(1'b0, 1'b0, 1'b0);
        tcyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        tcyc(1'b1, 1'b0, 1'b0);

        // 5: overrun, then ack coinciding with entry
        phase = "ovr";
        ir_load(8'h3C, 1'b0);
        chk("first_instr", 32'(ins_w[0]), 32'h0000_003C);
        ir_load(8'hC3, 1'b0);
        chk("keep_instr", 32'(ins_w[0]), 32'h0000_003C);
        chk("ovr_set", 32'(ovr_w[0]), 32'd1);
        ir_load(8'h5A, 1'b1);
        chk("ack_entry_instr", 32'(ins_w[1]), 32'h0000_005A);
        chk("ack_entry_req", 32'(req_w[1]), 32'd1);
        chk("ack_entry_ovr", 32'(ovr_w[1]), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("ovr_clr", 32'(ovr_w[0]), 32'd0);
        tcyc(1'b1, 1'b0, 1'b0);

        // 6: wrData ignored in SHIFT_D, async reset mid-shift
        phase = "rst_mid";
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
        goto_shift_d();
        for (int i = 0; i < 5; i++) tcyc(1'b0, 1'b1, 1'b0);
        chk("dr5_msb", 32'(rd_w[0]), 32'h0000_001F);
        chk("dr5_lsb", 32'(rd_w[1]), 32'h0000_F800);
        chk("cnt5", 32'(cnt_w[0]), 32'd5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        chk("wr_ignored", 32'(rd_w[0]), 32'h0000_001F);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_shd", 32'(shd_w[0]), 32'd0);
        chk("rst_dr", 32'(rd_w[1]), 32'd0);
        chk("rst_cnt", 32'(cnt_w[0]), 32'd0);
        check_all();
        @(posedge clk); #1;
        rstn = 1'b1;

        // Randomised traffic against the model
        phase = "rand";
        for (int i = 0; i < 800; i++) begin
            logic t;
            t = ($urandom_range(0, 1) == 0) ? ~tck : tck;
            cyc(t, ($urandom_range(0, 2) == 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
                16'($urandom), ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
